float_mul_issue: RTL and testbench

- Operand front-end placed directly upstream of the chunked float multiplier (float_mul_pipeline).
- Accepts operand pairs on a valid/ready stream and buffers them in a small FIFO.
- Issues one single-cycle, flop-driven req per pair, waits for the multiplier's ack, and returns results in order on a valid/ready stream with the caller's tag.
- Zero operands bypass the multiplier, which has no zero handling.

---
 rtl/float_mul_issue.sv | 211 +++++++++++++++++++++
 tb/tb_float_mul_issue.sv | 392 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/float_mul_issue.sv
// float_mul_issue
// Operand front-end for the chunked float multiplier (float_mul_pipeline).
// Operand pairs arrive on a valid/ready stream and are buffered in a small
// FIFO. Each pair goes to the multiplier as a single-cycle, flop-driven
// request. Results return in input order on a valid/ready stream, together
// with the caller's tag. The multiplier has no zero handling, so a pair with
// a zero operand bypasses it and produces a signed zero here.
//
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   in_valid/in_ready            operand stream handshake
//   in_a, in_b, in_tag           operand pair and opaque caller tag
//   mul_req, mul_a, mul_b        registered request to the multiplier
//   mul_ack, mul_out             one-cycle result strobe and product
//   res_valid/res_ready          result stream handshake
//   res_data, res_tag            product and tag of the originating pair
//   busy                         work is queued, in flight or being held
module float_mul_issue #(
    parameter int float_width      = 32,
    parameter int float_exp_width  = 8,
    parameter int float_mant_width = 23,
    parameter int FIFO_DEPTH       = 4,
    parameter int TAG_WIDTH        = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [float_width-1:0] in_a,
    input  logic [float_width-1:0] in_b,
    input  logic [TAG_WIDTH-1:0]   in_tag,
    output logic                   mul_req,
    output logic [float_width-1:0] mul_a,
    output logic [float_width-1:0] mul_b,
    input  logic                   mul_ack,
    input  logic [float_width-1:0] mul_out,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [float_width-1:0] res_data,
    output logic [TAG_WIDTH-1:0]   res_tag,
    output logic                   busy
);

    // FIFO_DEPTH must be a power of two so the pointers wrap on their own.
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t state_r;
    state_t state_nxt;

    logic [float_width-1:0] fifo_a_r   [FIFO_DEPTH];
    logic [float_width-1:0] fifo_b_r   [FIFO_DEPTH];
    logic [TAG_WIDTH-1:0]   fifo_tag_r [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr_r;
    logic [PTR_W-1:0]       rd_ptr_r;
    logic [CNT_W-1:0]       count_r;
    logic [TAG_WIDTH-1:0]   tag_r;

    logic                   push_s;
    logic                   pop_s;
    logic                   issue_s;
    logic                   bypass_load_s;
    logic                   ack_load_s;
    logic                   slot_free_s;
    logic                   fifo_nonempty_s;
    logic                   head_zero_s;
    logic [float_width-1:0] head_a_s;
    logic [float_width-1:0] head_b_s;
    logic [TAG_WIDTH-1:0]   head_tag_s;

    // An exponent field of zero counts as zero; denormals flush to zero.
    function automatic logic is_zero(input logic [float_width-1:0] v);
        return (v[float_mant_width +: float_exp_width] == {float_exp_width{1'b0}});
    endfunction

    // Fullness comes from the registered count only, so a same-cycle pop
    // never lets a push into a full FIFO.
    assign in_ready        = (count_r != DEPTH_C);
    assign push_s          = in_valid && in_ready;
    assign fifo_nonempty_s = (count_r != {CNT_W{1'b0}});
    assign slot_free_s     = !res_valid || res_ready;
    assign head_a_s        = fifo_a_r[rd_ptr_r];
    assign head_b_s        = fifo_b_r[rd_ptr_r];
    assign head_tag_s      = fifo_tag_r[rd_ptr_r];
    assign head_zero_s     = is_zero(head_a_s) || is_zero(head_b_s);
    assign busy            = fifo_nonempty_s || (state_r == ST_WAIT) || res_valid;

    // Next-state and per-cycle action decode.
    always_comb begin
        state_nxt     = state_r;
        pop_s         = 1'b0;
        issue_s       = 1'b0;
        bypass_load_s = 1'b0;
        ack_load_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                // Late acks are ignored here.
                if (fifo_nonempty_s && slot_free_s) begin
                    pop_s = 1'b1;
                    if (head_zero_s) begin
                        bypass_load_s = 1'b1;
                        state_nxt     = ST_IDLE;
                    end else begin
                        issue_s   = 1'b1;
                        state_nxt = ST_WAIT;
                    end
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_WAIT: begin
                // The slot was free when we entered, so the ack always lands.
                if (mul_ack) begin
                    ack_load_s = 1'b1;
                    state_nxt  = ST_IDLE;
                end else begin
                    state_nxt = ST_WAIT;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt;
        end
    end

    // FIFO storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_a_r[wr_ptr_r]   <= in_a;
            fifo_b_r[wr_ptr_r]   <= in_b;
            fifo_tag_r[wr_ptr_r] <= in_tag;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Multiplier request: mul_req pulses for one cycle; operands and the
    // tag of the in-flight pair hold until the next issue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mul_req <= 1'b0;
            mul_a   <= {float_width{1'b0}};
            mul_b   <= {float_width{1'b0}};
            tag_r   <= {TAG_WIDTH{1'b0}};
        end else begin
            mul_req <= issue_s;
            if (issue_s) begin
                mul_a <= head_a_s;
                mul_b <= head_b_s;
                tag_r <= head_tag_s;
            end
        end
    end

    // Result slot: loaded by a zero bypass or an ack, emptied on accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_valid <= 1'b0;
            res_data  <= {float_width{1'b0}};
            res_tag   <= {TAG_WIDTH{1'b0}};
        end else begin
            if (bypass_load_s) begin
                res_valid <= 1'b1;
                res_data  <= {head_a_s[float_width-1] ^ head_b_s[float_width-1],
                              {(float_width-1){1'b0}}};
                res_tag   <= head_tag_s;
            end else if (ack_load_s) begin
                res_valid <= 1'b1;
                res_data  <= mul_out;
                res_tag   <= tag_r;
            end else if (res_ready) begin
                res_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_float_mul_issue.sv
module tb_float_mul_issue;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [3:0]  in_tag;
    logic        mul_req;
    logic [31:0] mul_a;
    logic [31:0] mul_b;
    logic        mul_ack;
    logic [31:0] mul_out;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
    logic [3:0]  res_tag;
    logic        busy;

    int vectors    = 0;
    int miscompares = 0;

    // multiplier model state
    int          req_count  = 0;
    int          ack_delay  = 2;
    bit          auto_ack   = 1'b1;
    int          stray_cnt  = 0;
    int          stray_done = 0;
    bit          pending    = 1'b0;
    int          delay      = 0;
    logic [31:0] pend_out   = 32'h0000_0000;
    logic [31:0] last_a     = 32'h0000_0000;
    logic [31:0] last_b     = 32'h0000_0000;

    logic [31:0] got_data[$];
    logic [3:0]  got_tag[$];

    logic [31:0] bp_a[6];
    logic [31:0] bp_b[6];
    logic [31:0] bp_p[6];

    float_mul_issue dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_tag    (in_tag),
        .mul_req   (mul_req),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_ack   (mul_ack),
        .mul_out   (mul_out),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_tag   (res_tag),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hand-computed IEEE-754 single products for the pairs used here.
    function automatic logic [31:0] prod(input logic [31:0] a, input logic [31:0] b);
        case ({a, b})
            {32'h4000_0000, 32'h4040_0000}: prod = 32'h40C0_0000; // 2*3
            {32'h3FC0_0000, 32'h3FC0_0000}: prod = 32'h4010_0000; // 1.5*1.5
            {32'h4080_0000, 32'h3F00_0000}: prod = 32'h4000_0000; // 4*0.5
            {32'h3F80_0000, 32'h4000_0000}: prod = 32'h4000_0000; // 1*2
            {32'h4000_0000, 32'h4000_0000}: prod = 32'h4080_0000; // 2*2
            {32'h4040_0000, 32'h4000_0000}: prod = 32'h40C0_0000; // 3*2
            {32'h3F00_0000, 32'h3F00_0000}: prod = 32'h3E80_0000; // 0.5*0.5
            {32'h40A0_0000, 32'h4000_0000}: prod = 32'h4120_0000; // 5*2
            default:                        prod = 32'hDEAD_BEEF;
        endcase
    endfunction

    // Multiplier model: latches each request, acks after ack_delay cycles.
    always begin
        @(posedge clk);
        #1;
        mul_ack = 1'b0;
        if (rst) begin
            pending = 1'b0;
        end else begin
            if (stray_cnt != stray_done) begin
                stray_done = stray_cnt;
                mul_ack    = 1'b1;
                mul_out    = 32'h1234_5678;
            end else if (pending && auto_ack) begin
                if (delay == 0) begin
                    mul_ack = 1'b1;
                    mul_out = pend_out;
                    pending = 1'b0;
                end else begin
                    delay = delay - 1;
                end
            end
            if (mul_req) begin
                req_count = req_count + 1;
                last_a    = mul_a;
                last_b    = mul_b;
                pend_out  = prod(mul_a, mul_b);
                pending   = 1'b1;
                delay     = ack_delay;
            end
        end
    end

    // Result scoreboard: record every accepted result.
    always @(negedge clk) begin
        if (!rst && res_valid && res_ready) begin
            got_data.push_back(res_data);
            got_tag.push_back(res_tag);
        end
    end

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [3:0] t);
        int n;
        n = 0;
        in_a = a; in_b = b; in_tag = t; in_valid = 1'b1;
        while (!in_ready && n < 200) begin
            tick(1);
            n++;
        end
        vectors++;
        if (!in_ready) begin
            miscompares++;
            $display("FAIL push_timeout: in_ready=%0b required 1", in_ready);
        end
        tick(1);
        in_valid = 1'b0;
    endtask

    task automatic wait_results(input int n);
        int c;
        c = 0;
        while (got_data.size() < n && c < 200) begin
            tick(1);
            c++;
        end
        vectors++;
        if (got_data.size() < n) begin
            miscompares++;
            $display("FAIL result_timeout: got %0d results, required %0d", got_data.size(), n);
        end
    endtask

    task automatic clear_results();
        got_data.delete();
        got_tag.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; res_ready = 1'b0; in_a = 32'h0; in_b = 32'h0;
        in_tag = 4'h0; mul_ack = 1'b0; mul_out = 32'h0;
        tick(3);
        vectors++;
        if ({in_ready, mul_req, mul_a, mul_b, res_valid, res_data, res_tag, busy} !==
            {1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_outputs: rdy=%0b req=%0b a=%h b=%h rv=%0b rd=%h rt=%h busy=%0b required 1 0 0 0 0 0 0 0",
                     in_ready, mul_req, mul_a, mul_b, res_valid, res_data, res_tag, busy);
        end
        rst = 1'b0;
        tick(1);
    endtask

    task automatic test_single();
        int r0;
        clear_results();
        res_ready = 1'b1;
        r0 = req_count;
        push(32'h4000_0000, 32'h4040_0000, 4'd3);
        wait_results(1);
        vectors++;
        if (req_count - r0 !== 1) begin
            miscompares++;
            $display("FAIL single_req_cycles: %0d required 1", req_count - r0);
        end
        vectors++;
        if (last_a !== 32'h4000_0000 || last_b !== 32'h4040_0000) begin
            miscompares++;
            $display("FAIL single_operands: a=%h b=%h required 40000000 40400000", last_a, last_b);
        end
        vectors++;
        if (got_data.size() != 1 || got_data[0] !== 32'h40C0_0000 || got_tag[0] !== 4'd3) begin
            miscompares++;
            $display("FAIL single_result: n=%0d data=%h tag=%h required 1 40c00000 3",
                     got_data.size(), (got_data.size() > 0) ? got_data[0] : 32'hx,
                     (got_tag.size() > 0) ? got_tag[0] : 4'hx);
        end
        vectors++;
        if (res_valid !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL single_drop: res_valid=%0b busy=%0b required 0 0", res_valid, busy);
        end
    endtask

    task automatic test_back_to_back();
        int r0;
        clear_results();
        res_ready = 1'b1;
        r0 = req_count;
        push(32'h3FC0_0000, 32'h3FC0_0000, 4'd1);
        push(32'h4080_0000, 32'h3F00_0000, 4'd2);
        wait_results(2);
        tick(2);
        vectors++;
        if (req_count - r0 !== 2) begin
            miscompares++;
            $display("FAIL b2b_req_pulses: %0d required 2", req_count - r0);
        end
        vectors++;
        if (got_data.size() != 2 || got_data[0] !== 32'h4010_0000 || got_tag[0] !== 4'd1 ||
            got_data[1] !== 32'h4000_0000 || got_tag[1] !== 4'd2) begin
            miscompares++;
            $display("FAIL b2b_results: n=%0d first=%h/%h second=%h/%h required 40100000/1 40000000/2",
                     got_data.size(), (got_data.size() > 0) ? got_data[0] : 32'hx,
                     (got_tag.size() > 0) ? got_tag[0] : 4'hx,
                     (got_data.size() > 1) ? got_data[1] : 32'hx,
                     (got_tag.size() > 1) ? got_tag[1] : 4'hx);
        end
    endtask

    task automatic test_zero_bypass();
        int          r0;
        logic [31:0] za[3];
        logic [31:0] zb[3];
        logic [31:0] zp[3];
        za[0] = 32'h8000_0000; zb[0] = 32'h4040_0000; zp[0] = 32'h8000_0000;
        za[1] = 32'hC040_0000; zb[1] = 32'h0040_0000; zp[1] = 32'h8000_0000;
        za[2] = 32'h3F80_0000; zb[2] = 32'h0000_0001; zp[2] = 32'h0000_0000;
        clear_results();
        res_ready = 1'b1;
        r0 = req_count;
        for (int i = 0; i < 3; i++) begin
            push(za[i], zb[i], 4'(5 + i));
            tick(1);
            vectors++;
            if (res_valid !== 1'b1 || res_data !== zp[i] || res_tag !== 4'(5 + i)) begin
                miscompares++;
                $display("FAIL zero_bypass_%0d: valid=%0b data=%h tag=%h required 1 %h %h",
                         i, res_valid, res_data, res_tag, zp[i], 4'(5 + i));
            end
            tick(2);
        end
        vectors++;
        if (req_count - r0 !== 0) begin
            miscompares++;
            $display("FAIL zero_no_req: %0d required 0", req_count - r0);
        end
        vectors++;
        if (got_data.size() != 3) begin
            miscompares++;
            $display("FAIL zero_count: %0d required 3", got_data.size());
        end
    endtask

    task automatic test_backpressure();
        int          r0;
        int          i;
        bit          acc;
        logic [31:0] held;
        bp_a[0] = 32'h3F80_0000; bp_b[0] = 32'h4000_0000; bp_p[0] = 32'h4000_0000;
        bp_a[1] = 32'h4000_0000; bp_b[1] = 32'h4000_0000; bp_p[1] = 32'h4080_0000;
        bp_a[2] = 32'h4040_0000; bp_b[2] = 32'h4000_0000; bp_p[2] = 32'h40C0_0000;
        bp_a[3] = 32'h0000_0000; bp_b[3] = 32'h4000_0000; bp_p[3] = 32'h0000_0000;
        bp_a[4] = 32'h3F00_0000; bp_b[4] = 32'h3F00_0000; bp_p[4] = 32'h3E80_0000;
        bp_a[5] = 32'h40A0_0000; bp_b[5] = 32'h4000_0000; bp_p[5] = 32'h4120_0000;
        clear_results();
        res_ready = 1'b0;
        r0 = req_count;
        i = 0;
        held = 32'h0;
        for (int c = 0; c < 30; c++) begin
            if (i < 6) begin
                in_a = bp_a[i]; in_b = bp_b[i]; in_tag = 4'(8 + i); in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            acc = in_ready && (i < 6);
            tick(1);
            if (acc) i++;
            if (c == 10) held = res_data;
        end
        vectors++;
        if (i !== 5 || in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_fill: accepted=%0d in_ready=%0b required 5 0", i, in_ready);
        end
        vectors++;
        if (res_valid !== 1'b1 || res_data !== bp_p[0] || res_tag !== 4'd8 || held !== bp_p[0]) begin
            miscompares++;
            $display("FAIL bp_hold: valid=%0b data=%h tag=%h early=%h required 1 %h 8 %h",
                     res_valid, res_data, res_tag, held, bp_p[0], bp_p[0]);
        end
        vectors++;
        if (req_count - r0 !== 1 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_no_issue: reqs=%0d busy=%0b required 1 1", req_count - r0, busy);
        end
        res_ready = 1'b1;
        for (int c = 0; c < 60; c++) begin
            if (i < 6) begin
                in_a = bp_a[i]; in_b = bp_b[i]; in_tag = 4'(8 + i); in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            acc = in_ready && (i < 6);
            tick(1);
            if (acc) i++;
        end
        in_valid = 1'b0;
        wait_results(6);
        vectors++;
        if (i !== 6) begin
            miscompares++;
            $display("FAIL bp_resume: accepted=%0d required 6", i);
        end
        for (int k = 0; k < 6; k++) begin
            vectors++;
            if (k >= got_data.size()) begin
                miscompares++;
                $display("FAIL bp_order_%0d: missing result, required %h tag %h", k, bp_p[k], 4'(8 + k));
            end else if (got_data[k] !== bp_p[k] || got_tag[k] !== 4'(8 + k)) begin
                miscompares++;
                $display("FAIL bp_order_%0d: data=%h tag=%h required %h %h",
                         k, got_data[k], got_tag[k], bp_p[k], 4'(8 + k));
            end
        end
    endtask

    task automatic test_reset_mid();
        int r0;
        clear_results();
        res_ready = 1'b1;
        auto_ack  = 1'b0;
        push(32'h4000_0000, 32'h4040_0000, 4'd1);
        push(32'h3FC0_0000, 32'h3FC0_0000, 4'd2);
        push(32'h4080_0000, 32'h3F00_0000, 4'd4);
        tick(3);
        vectors++;
        if (busy !== 1'b1 || mul_a !== 32'h4000_0000) begin
            miscompares++;
            $display("FAIL rst_pre_wait: busy=%0b mul_a=%h required 1 40000000", busy, mul_a);
        end
        rst = 1'b1;
        tick(1);
        vectors++;
        if ({in_ready, mul_req, mul_a, mul_b, res_valid, res_data, res_tag, busy} !==
            {1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0}) begin
            miscompares++;
            $display("FAIL rst_mid_outputs: rdy=%0b req=%0b a=%h b=%h rv=%0b rd=%h rt=%h busy=%0b required 1 0 0 0 0 0 0 0",
                     in_ready, mul_req, mul_a, mul_b, res_valid, res_data, res_tag, busy);
        end
        rst = 1'b0;
        auto_ack = 1'b1;
        r0 = req_count;
        tick(1);
        stray_cnt = stray_cnt + 1;
        tick(6);
        vectors++;
        if (res_valid !== 1'b0 || busy !== 1'b0 || got_data.size() != 0 || req_count != r0) begin
            miscompares++;
            $display("FAIL rst_stray_ack: res_valid=%0b busy=%0b results=%0d reqs=%0d required 0 0 0 0",
                     res_valid, busy, got_data.size(), req_count - r0);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_zero_bypass();
        test_backpressure();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
